// File: rtl/simple_datapath_pkg.sv
// Shared constants for the 4-bit simple computer: widths, FS opcodes, flag layout.
// Pure declarations; no latency and no flow control.
package simple_datapath_pkg;

  localparam int DATA_W    = 4;
  localparam int REG_AW    = 2;
  localparam int MEM_AW    = 4;
  localparam int NUM_REGS  = 1 << REG_AW;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  typedef enum logic [3:0] {
    FS_PASSA  = 4'b0000,
    FS_INCA   = 4'b0001,
    FS_ADD    = 4'b0010,
    FS_ADDC   = 4'b0011,
    FS_ADDNB  = 4'b0100,
    FS_SUB    = 4'b0101,
    FS_DECA   = 4'b0110,
    FS_PASSA2 = 4'b0111,
    FS_AND    = 4'b1000,
    FS_OR     = 4'b1001,
    FS_XOR    = 4'b1010,
    FS_NOTA   = 4'b1011,
    FS_PASSB  = 4'b1100,
    FS_SHR    = 4'b1101,
    FS_SHL    = 4'b1110,
    FS_ZERO   = 4'b1111
  } fs_e;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

  // The whole lower half of the FS space goes through the adder.
  function automatic logic is_arith(input logic [3:0] fs);
    return ~fs[3];
  endfunction

endpackage

// File: rtl/simple_datapath_reg_file.sv
// 4x4-bit register file: two combinational read ports, one write port, sync reset.
// Reads are same-cycle, writes land on the rising edge (no bypass); no backpressure.
module simple_datapath_reg_file
  import simple_datapath_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra_a,
  input  logic [REG_AW-1:0] ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a = regs[ra_a];
  assign rd_b = regs[ra_b];

endmodule

// File: rtl/simple_datapath.sv
// Single-cycle datapath: register file, function unit, 16x4 data memory, registered V/C/N/Z.
// Buses and FOut are combinational; state updates on the next edge; no backpressure.
module simple_datapath
  import simple_datapath_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] DA,
  input  logic [REG_AW-1:0] AA,
  input  logic [REG_AW-1:0] BA,
  input  logic              MB,
  input  logic [3:0]        FS,
  input  logic              MD,
  input  logic              RW,
  input  logic              MW,
  input  logic [DATA_W-1:0] Constant,
  output logic [DATA_W-1:0] AData,
  output logic [DATA_W-1:0] BData,
  output logic [DATA_W-1:0] FOut,
  output logic              V,
  output logic              C,
  output logic              N,
  output logic              Z
);

  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] mem_out;
  logic [DATA_W-1:0] wb_dat;
  logic [DATA_W-1:0] add_y;
  logic              add_cin;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W-1:0] fu_dat;
  logic              fu_c;
  logic              fu_v;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  flags_t            flags_q;

  simple_datapath_reg_file reg_file (
    .clk  (CLK),
    .rst  (RST),
    .we   (RW),
    .wa   (DA),
    .wd   (wb_dat),
    .ra_a (AA),
    .ra_b (BA),
    .rd_a (reg_a),
    .rd_b (reg_b)
  );

  assign AData = reg_a;
  assign BData = MB ? Constant : reg_b;

  // Every arithmetic code is A + y + cin; only the second operand and carry-in differ.
  always_comb begin
    add_y   = '0;
    add_cin = 1'b0;
    case (FS)
      FS_INCA:  add_cin = 1'b1;
      FS_ADD:   add_y   = BData;
      FS_ADDC:  begin add_y = BData;  add_cin = 1'b1; end
      FS_ADDNB: add_y   = ~BData;
      FS_SUB:   begin add_y = ~BData; add_cin = 1'b1; end
      FS_DECA:  add_y   = '1;
      default:  add_y   = '0;
    endcase
  end

  assign add_sum = {1'b0, AData} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};

  always_comb begin
    fu_dat = '0;
    case (FS)
      FS_AND:   fu_dat = AData & BData;
      FS_OR:    fu_dat = AData | BData;
      FS_XOR:   fu_dat = AData ^ BData;
      FS_NOTA:  fu_dat = ~AData;
      FS_PASSB: fu_dat = BData;
      FS_SHR:   fu_dat = {1'b0, BData[DATA_W-1:1]};
      FS_SHL:   fu_dat = {BData[DATA_W-2:0], 1'b0};
      FS_ZERO:  fu_dat = '0;
      default:  fu_dat = add_sum[DATA_W-1:0];
    endcase
  end

  // Overflow: operands agree in sign but the sum does not.
  assign fu_c = is_arith(FS) & add_sum[DATA_W];
  assign fu_v = is_arith(FS) & (AData[DATA_W-1] == add_y[DATA_W-1])
                             & (add_sum[DATA_W-1] != AData[DATA_W-1]);
  assign FOut = fu_dat;

  assign mem_out = mem[AData];
  assign wb_dat  = MD ? mem_out : FOut;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (MW) begin
      mem[AData] <= BData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q <= '0;
    end else begin
      flags_q <= '{v: fu_v, c: fu_c, n: fu_dat[DATA_W-1], z: (fu_dat == '0)};
    end
  end

  assign V = flags_q.v;
  assign C = flags_q.c;
  assign N = flags_q.n;
  assign Z = flags_q.z;

endmodule

// File: tb/tb_simple_datapath.sv
// Scoreboard bench for simple_datapath: integer-arithmetic reference model, directed then random.
module tb_simple_datapath;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] DA, AA, BA;
  logic       MB, MD, RW, MW;
  logic [3:0] FS, Constant;
  logic [3:0] AData, BData, FOut;
  logic       V, C, N, Z;

  simple_datapath dut (
    .CLK(CLK), .RST(RST), .DA(DA), .AA(AA), .BA(BA), .MB(MB), .FS(FS),
    .MD(MD), .RW(RW), .MW(MW), .Constant(Constant),
    .AData(AData), .BData(BData), .FOut(FOut), .V(V), .C(C), .N(N), .Z(Z)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] f;
    logic       v, c, n, z;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  int   mr[4];
  int   mm[16];
  bit   mv, mc, mn, mz;

  function automatic int to_signed(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Reference function unit from plain integer arithmetic.
  function automatic void fu_ref(input int fs, input int a, input int b,
                                 output int f, output bit c, output bit v);
    int u, s, sa, sb;
    bit arith;
    sa = to_signed(a);
    sb = to_signed(b);
    u = 0; s = 0; arith = 1'b1; f = 0;
    case (fs)
      0, 7: begin u = a;            s = sa;          end
      1:    begin u = a + 1;        s = sa + 1;      end
      2:    begin u = a + b;        s = sa + sb;     end
      3:    begin u = a + b + 1;    s = sa + sb + 1; end
      4:    begin u = a + (15 - b); s = sa - sb - 1; end
      5:    begin u = a + (16 - b); s = sa - sb;     end
      6:    begin u = a + 15;       s = sa - 1;      end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      f = u % 16;
      c = (u >= 16);
      v = (s > 7) || (s < -8);
    end else begin
      c = 1'b0;
      v = 1'b0;
      case (fs)
        8:  f = a & b;
        9:  f = a | b;
        10: f = a ^ b;
        11: f = 15 - a;
        12: f = b;
        13: f = b / 2;
        14: f = (b * 2) % 16;
        default: f = 0;
      endcase
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++)  mr[i] = 0;
    for (int i = 0; i < 16; i++) mm[i] = 0;
    {mv, mc, mn, mz} = 4'b0;
  endtask

  // Drive one cycle of control, predict outputs from the pre-edge model, then advance the model.
  task automatic apply(input bit rst, input int da, input int aa, input int ba, input bit mb,
                       input int fs, input bit md, input bit rw, input bit mw, input int k);
    int a, b, f, memout;
    bit c, v;
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst; DA = 2'(da); AA = 2'(aa); BA = 2'(ba); MB = mb; FS = 4'(fs);
    MD = md; RW = rw; MW = mw; Constant = 4'(k);
    a = mr[aa];
    b = mb ? k : mr[ba];
    fu_ref(fs, a, b, f, c, v);
    memout = mm[a];
    e.a = 4'(a); e.b = 4'(b); e.f = 4'(f);
    e.v = mv; e.c = mc; e.n = mn; e.z = mz;
    sbq.push_back(e);
    if (rst) begin
      model_clear();
    end else begin
      if (rw) mr[da] = md ? memout : f;
      if (mw) mm[a] = b;
      mv = v; mc = c; mn = (f >= 8); mz = (f == 0);
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at time %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("AData", AData, e.a);
      chk("BData", BData, e.b);
      chk("FOut",  FOut,  e.f);
      chk("V", {3'b0, V}, {3'b0, e.v});
      chk("C", {3'b0, C}, {3'b0, e.c});
      chk("N", {3'b0, N}, {3'b0, e.n});
      chk("Z", {3'b0, Z}, {3'b0, e.z});
    end
  end

  initial begin
    RST = 1'b1; DA = '0; AA = '0; BA = '0; MB = 1'b0; FS = '0;
    MD = 1'b0; RW = 1'b0; MW = 1'b0; Constant = '0;
    model_clear();

    // reset state, then load-and-add (5+3 -> 8, N=V=1)
    apply(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 1, 4'hC, 0, 1, 0, 5);
    apply(0, 2, 0, 0, 1, 4'hC, 0, 1, 0, 3);
    apply(0, 3, 1, 2, 0, 4'h2, 0, 1, 0, 0);
    apply(0, 0, 3, 0, 0, 4'h0, 0, 0, 0, 0);
    // subtract with borrow, then swapped
    apply(0, 1, 0, 0, 1, 4'hC, 0, 1, 0, 3);
    apply(0, 2, 0, 0, 1, 4'hC, 0, 1, 0, 5);
    apply(0, 0, 1, 2, 0, 4'h5, 0, 0, 0, 0);
    apply(0, 0, 2, 1, 0, 4'h5, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    // memory round trip: M[7]=9, then R0 <= M[7]
    apply(0, 1, 0, 0, 1, 4'hC, 0, 1, 0, 7);
    apply(0, 2, 0, 0, 1, 4'hC, 0, 1, 0, 9);
    apply(0, 0, 1, 2, 0, 4'h0, 0, 0, 1, 0);
    apply(0, 0, 1, 0, 0, 4'h0, 1, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    // same-edge RW+MW with MD=1: register sees old word
    apply(0, 0, 0, 0, 1, 4'hC, 0, 1, 0, 1);
    apply(0, 0, 1, 0, 1, 4'h0, 1, 1, 1, 4);
    apply(0, 2, 1, 0, 0, 4'h0, 1, 1, 0, 0);
    apply(0, 0, 0, 2, 0, 4'h0, 0, 0, 0, 0);
    // reset mid-program with writes requested
    apply(0, 3, 0, 0, 1, 4'hC, 0, 1, 0, 8);
    apply(1, 3, 1, 2, 0, 4'h2, 1, 1, 1, 0);
    apply(0, 0, 3, 1, 0, 4'h0, 1, 1, 0, 0);
    apply(0, 0, 2, 0, 0, 4'h1, 0, 0, 0, 0);
    // boundary values: 7+1, 8-1, 0-1, F+1
    apply(0, 1, 0, 0, 1, 4'hC, 0, 1, 0, 7);
    apply(0, 2, 0, 0, 1, 4'hC, 0, 1, 0, 8);
    apply(0, 0, 1, 0, 0, 4'h1, 0, 0, 0, 0);
    apply(0, 0, 2, 0, 0, 4'h6, 0, 0, 0, 0);
    apply(0, 0, 3, 0, 0, 4'h6, 0, 0, 0, 0);
    apply(0, 3, 0, 0, 1, 4'hC, 0, 1, 0, 15);
    apply(0, 0, 3, 0, 0, 4'h1, 0, 0, 0, 0);
    apply(0, 0, 1, 2, 0, 4'h3, 0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      apply($urandom_range(0, 59) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 15), 1'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 15));
    end

    @(posedge CLK);
    #1;
    RW = 1'b0; MW = 1'b0; RST = 1'b0;
    @(negedge CLK);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
